// File: rtl/noc_pe_interface_pkg.sv
// Shared NoC definitions: default flit geometry and helpers for payload width and header extraction.
package noc_pe_interface_pkg;

  localparam int unsigned NocDataWidth = 36;
  localparam int unsigned NocAddrWidth = 4;
  localparam int unsigned MaxFlitWidth = 64;

  function automatic int unsigned payload_width(int unsigned dw, int unsigned aw);
    return dw - aw;
  endfunction

  // Destination header sits in the flit MSBs; result is right-aligned and zero-extended.
  function automatic logic [31:0] flit_header(logic [MaxFlitWidth-1:0] flit, int unsigned dw,
                                              int unsigned aw);
    logic [MaxFlitWidth-1:0] shifted;
    shifted = flit >> (dw - aw);
    return shifted[31:0] & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides.
module noc_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [Width-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [Width-1:0] rd_data_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push, pop;

  // Full check uses registered occupancy only, so a same-cycle read never frees a slot.
  assign wr_ready_o = (cnt_q != CntW'(Depth));
  assign rd_valid_o = (cnt_q != '0);
  assign push       = wr_valid_i & wr_ready_o;
  assign pop        = rd_valid_o & rd_ready_i;
  assign rd_data_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q + PtrW'(push);
    rptr_d = rptr_q + PtrW'(pop);
    cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/noc_pe_interface.sv
// Network interface between a PE and its leaf switch: TX packetiser FIFO, RX address filter FIFO.
module noc_pe_interface
  import noc_pe_interface_pkg::*;
#(
  parameter int unsigned DataWidth = NocDataWidth,
  parameter int unsigned AddrWidth = NocAddrWidth,
  parameter int unsigned MyAddr    = 0,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                                           i_sclk,
  input  logic                                           i_reset_n,
  input  logic [payload_width(DataWidth, AddrWidth)-1:0] i_pe_data,
  input  logic [AddrWidth-1:0]                           i_pe_dest,
  input  logic                                           i_pe_valid,
  output logic                                           o_pe_ready,
  output logic [DataWidth-1:0]                           o_data,
  output logic                                           o_data_valid,
  input  logic                                           i_data_ready,
  input  logic [DataWidth-1:0]                           i_data,
  input  logic                                           i_data_valid,
  output logic                                           o_data_ready,
  output logic [payload_width(DataWidth, AddrWidth)-1:0] o_pe_data,
  output logic                                           o_pe_valid,
  input  logic                                           i_pe_ready,
  output logic [7:0]                                     o_drop_count,
  output logic [15:0]                                    o_tx_count,
  output logic [15:0]                                    o_rx_count
);

  localparam int unsigned PayloadWidth = payload_width(DataWidth, AddrWidth);

  // Assertion is immediate; release passes through two flops before the datapath wakes up.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  logic tx_wr_ready, rx_wr_ready, hdr_match, rx_accept, rx_drop, tx_xfer, rx_xfer;

  assign o_pe_ready   = tx_wr_ready & rst_int_n;
  assign o_data_ready = rx_wr_ready & rst_int_n;
  assign hdr_match    = (flit_header(MaxFlitWidth'(i_data), DataWidth, AddrWidth) == MyAddr);
  assign rx_accept    = i_data_valid & o_data_ready;
  assign rx_drop      = rx_accept & ~hdr_match;
  assign tx_xfer      = o_data_valid & i_data_ready;
  assign rx_xfer      = o_pe_valid & i_pe_ready;

  noc_sync_fifo #(
    .Width (DataWidth),
    .Depth (FifoDepth)
  ) u_tx_fifo (
    .clk_i      (i_sclk),
    .rst_ni     (rst_int_n),
    .wr_valid_i (i_pe_valid & rst_int_n),
    .wr_ready_o (tx_wr_ready),
    .wr_data_i  ({i_pe_dest, i_pe_data}),
    .rd_valid_o (o_data_valid),
    .rd_ready_i (i_data_ready),
    .rd_data_o  (o_data)
  );

  noc_sync_fifo #(
    .Width (PayloadWidth),
    .Depth (FifoDepth)
  ) u_rx_fifo (
    .clk_i      (i_sclk),
    .rst_ni     (rst_int_n),
    .wr_valid_i (rx_accept & hdr_match),
    .wr_ready_o (rx_wr_ready),
    .wr_data_i  (i_data[PayloadWidth-1:0]),
    .rd_valid_o (o_pe_valid),
    .rd_ready_i (i_pe_ready),
    .rd_data_o  (o_pe_data)
  );

  logic [15:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [7:0]  drop_count_q, drop_count_d;

  always_comb begin
    tx_count_d   = tx_count_q;
    rx_count_d   = rx_count_q;
    drop_count_d = drop_count_q;
    if (tx_xfer) tx_count_d = tx_count_q + 16'd1;
    if (rx_xfer) rx_count_d = rx_count_q + 16'd1;
    if (rx_drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge i_sclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tx_count_q   <= '0;
      rx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      tx_count_q   <= tx_count_d;
      rx_count_q   <= rx_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign o_tx_count   = tx_count_q;
  assign o_rx_count   = rx_count_q;
  assign o_drop_count = drop_count_q;

endmodule

// File: tb/tb_noc_pe_interface.sv
// Bench for noc_pe_interface: queue-based reference model, per-cycle compare, directed + random traffic.
module tb_noc_pe_interface;

  localparam int unsigned DW    = 36;
  localparam int unsigned AW    = 4;
  localparam int unsigned PW    = 32;
  localparam int unsigned Depth = 4;
  localparam logic [3:0]  MyA   = 4'd0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] pe_data;
  logic [AW-1:0] pe_dest;
  logic          pe_valid, o_pe_ready;
  logic [DW-1:0] o_data;
  logic          o_data_valid, data_ready;
  logic [DW-1:0] d_data;
  logic          d_valid, o_data_ready;
  logic [PW-1:0] o_pe_data;
  logic          o_pe_valid, pe_ready;
  logic [7:0]    o_drop_count;
  logic [15:0]   o_tx_count, o_rx_count;

  always #5 clk = ~clk;

  noc_pe_interface #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .MyAddr    (0),
    .FifoDepth (Depth)
  ) dut (
    .i_sclk       (clk),
    .i_reset_n    (rst_n),
    .i_pe_data    (pe_data),
    .i_pe_dest    (pe_dest),
    .i_pe_valid   (pe_valid),
    .o_pe_ready   (o_pe_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ready (data_ready),
    .i_data       (d_data),
    .i_data_valid (d_valid),
    .o_data_ready (o_data_ready),
    .o_pe_data    (o_pe_data),
    .o_pe_valid   (o_pe_valid),
    .i_pe_ready   (pe_ready),
    .o_drop_count (o_drop_count),
    .o_tx_count   (o_tx_count),
    .o_rx_count   (o_rx_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queues of buffered flits/payloads and plain counters.
  logic [DW-1:0] txq [$];
  logic [PW-1:0] rxq [$];
  int            sync_n = 0;
  int            tx_cnt = 0, rx_cnt = 0, drop_cnt = 0;
  bit            m_tx_push = 0, m_rx_acc = 0;
  bit            auto_mode = 0;

  always @(posedge clk or negedge rst_n) begin : model
    bit ok, tpush, tpop, racc, rdel;
    if (!rst_n) begin
      txq.delete();
      rxq.delete();
      sync_n    = 0;
      tx_cnt    = 0;
      rx_cnt    = 0;
      drop_cnt  = 0;
      m_tx_push = 0;
      m_rx_acc  = 0;
    end else begin
      ok    = (sync_n >= 2);
      tpush = ok && pe_valid && (txq.size() < Depth);
      tpop  = (txq.size() > 0) && data_ready;
      racc  = ok && d_valid && (rxq.size() < Depth);
      rdel  = (rxq.size() > 0) && pe_ready;
      if (tpop) begin
        void'(txq.pop_front());
        tx_cnt = (tx_cnt + 1) % 65536;
      end
      if (tpush) txq.push_back({pe_dest, pe_data});
      if (rdel) begin
        void'(rxq.pop_front());
        rx_cnt = (rx_cnt + 1) % 65536;
      end
      if (racc) begin
        if (d_data[DW-1 -: AW] == MyA) rxq.push_back(d_data[PW-1:0]);
        else if (drop_cnt < 255) drop_cnt = drop_cnt + 1;
      end
      m_tx_push = tpush;
      m_rx_acc  = racc;
      if (sync_n < 2) sync_n = sync_n + 1;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake got none within bound, expected one at t=%0t", name, $time);
  endtask

  task automatic compare_all();
    bit ok;
    ok = rst_n && (sync_n >= 2);
    chk("pe_ready", o_pe_ready, ok && (txq.size() < Depth));
    chk("data_valid", o_data_valid, txq.size() > 0);
    if (txq.size() > 0) chk("data", o_data, txq[0]);
    chk("data_ready", o_data_ready, ok && (rxq.size() < Depth));
    chk("pe_valid", o_pe_valid, rxq.size() > 0);
    if (rxq.size() > 0) chk("pe_data", o_pe_data, rxq[0]);
    chk("tx_count", o_tx_count, tx_cnt);
    chk("rx_count", o_rx_count, rx_cnt);
    chk("drop_count", o_drop_count, drop_cnt);
  endtask

  task automatic step();
    logic [3:0] hdr;
    @(posedge clk);
    #2;
    if (auto_mode) begin
      if (!pe_valid || m_tx_push) begin
        pe_valid = ($urandom_range(99) < 60);
        pe_dest  = 4'($urandom);
        pe_data  = $urandom;
      end
      data_ready = ($urandom_range(99) < 55);
      if (!d_valid || m_rx_acc) begin
        d_valid = ($urandom_range(99) < 60);
        hdr     = ($urandom_range(99) < 65) ? MyA : 4'($urandom_range(1, 15));
        d_data  = {hdr, 32'($urandom)};
      end
      pe_ready = ($urandom_range(99) < 50);
    end
  endtask

  task automatic push_tx(logic [3:0] dest, logic [31:0] data, int bound);
    pe_dest  = dest;
    pe_data  = data;
    pe_valid = 1'b1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (m_tx_push) begin
        pe_valid = 1'b0;
        return;
      end
    end
    pe_valid = 1'b0;
    timeout("tx_push");
  endtask

  task automatic push_rx(logic [35:0] flit, int bound);
    d_data  = flit;
    d_valid = 1'b1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (m_rx_acc) begin
        d_valid = 1'b0;
        return;
      end
    end
    d_valid = 1'b0;
    timeout("rx_push");
  endtask

  logic [35:0] exp_tx [5] = '{36'h1A0000000, 36'h2A0000001, 36'h3A0000002, 36'h4A0000003,
                              36'h5A0000004};

  initial begin
    rst_n = 1'b0;
    pe_valid = 1'b0; pe_dest = '0; pe_data = '0; data_ready = 1'b0;
    d_valid = 1'b0; d_data = '0; pe_ready = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    // Reset and synchronised release
    repeat (3) step();
    @(negedge clk);
    chk("rst_pe_ready", o_pe_ready, 0);
    chk("rst_data_ready", o_data_ready, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("sync_edge0", o_pe_ready, 0);
    step();
    @(negedge clk);
    chk("sync_edge1", o_pe_ready, 0);
    step();
    @(negedge clk);
    chk("sync_edge2_pe_ready", o_pe_ready, 1);
    chk("sync_edge2_data_ready", o_data_ready, 1);

    // Single TX flit
    data_ready = 1'b1;
    pe_dest = 4'd3; pe_data = 32'h12345678; pe_valid = 1'b1;
    step();
    pe_valid = 1'b0;
    @(negedge clk);
    chk("s1_valid", o_data_valid, 1);
    chk("s1_flit", o_data, 36'h312345678);
    step();
    @(negedge clk);
    chk("s1_tx_count", o_tx_count, 1);

    // TX back-pressure: four accepted, fifth waits
    data_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_tx(exp_tx[k][35:32], exp_tx[k][31:0], 4);
    pe_dest = 4'h5; pe_data = 32'hA0000004; pe_valid = 1'b1;
    @(negedge clk);
    chk("s2_full", o_pe_ready, 0);
    step();
    @(negedge clk);
    chk("s2_still_full", o_pe_ready, 0);
    chk("s2_head", o_data, exp_tx[0]);
    data_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      if (m_tx_push) pe_valid = 1'b0;
      @(negedge clk);
      chk("s2_order", o_data, exp_tx[k]);
    end
    repeat (2) step();

    // RX matching flit
    pe_ready = 1'b1;
    d_data = 36'h0AABBCCDD; d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    @(negedge clk);
    chk("s3_valid", o_pe_valid, 1);
    chk("s3_payload", o_pe_data, 32'hAABBCCDD);
    step();
    @(negedge clk);
    chk("s3_rx_count", o_rx_count, 1);

    // RX full: misaddressed flit must wait
    pe_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_rx({4'h0, 32'h11110000 + 32'(k)}, 4);
    d_data = {4'h7, 32'hDEADBEEF}; d_valid = 1'b1;
    @(negedge clk);
    chk("s5_blocked", o_data_ready, 0);
    repeat (2) step();
    @(negedge clk);
    chk("s5_no_drop", o_drop_count, 0);
    pe_ready = 1'b1;
    step();
    pe_ready = 1'b0;
    @(negedge clk);
    chk("s5_slot_free", o_data_ready, 1);
    step();
    if (m_rx_acc) d_valid = 1'b0;
    @(negedge clk);
    chk("s5_drop", o_drop_count, 1);
    d_valid = 1'b0;
    pe_ready = 1'b1;
    repeat (4) step();

    // Drop counter saturation
    for (int k = 0; k < 300; k++) push_rx({4'h5, 32'($urandom)}, 6);
    @(negedge clk);
    chk("s4_drop_sat", o_drop_count, 255);
    chk("s4_no_delivery", o_pe_valid, 0);
    chk("s4_rx_count", o_rx_count, 5);
    chk("s4_ready", o_data_ready, 1);

    // Reset with both FIFOs partially full
    data_ready = 1'b0; pe_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_tx(4'(k), 32'hC0DE0000 + 32'(k), 4);
    for (int k = 0; k < 3; k++) push_rx({4'h0, 32'hFEED0000 + 32'(k)}, 4);
    step();
    rst_n = 1'b0;
    #1;
    chk("s6_tx_valid_drop", o_data_valid, 0);
    chk("s6_rx_valid_drop", o_pe_valid, 0);
    chk("s6_tx_count_clr", o_tx_count, 0);
    data_ready = 1'b1; pe_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("s6_no_stale_tx", o_data_valid, 0);
    chk("s6_no_stale_rx", o_pe_valid, 0);

    // Random traffic with a mid-run reset
    auto_mode = 1'b1;
    repeat (1500) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (1500) step();
    auto_mode = 1'b0;
    pe_valid = 1'b0; d_valid = 1'b0; data_ready = 1'b1; pe_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
